// File: rtl/wb_periph_mux_pkg.sv
// Shared types and default address map for the Wishbone peripheral mux.
package wb_periph_mux_pkg;

   localparam int NUM_SLAVES = 4;
   localparam int SEL_W      = 2;

   localparam logic [31:0] DEF_S0_BASE = 32'h0200_0000;
   localparam logic [31:0] DEF_S0_MASK = 32'hFFFF_0000;
   localparam logic [31:0] DEF_S1_BASE = 32'h1000_0000;
   localparam logic [31:0] DEF_S1_MASK = 32'hFFFF_F000;
   localparam logic [31:0] DEF_S2_BASE = 32'h8000_0000;
   localparam logic [31:0] DEF_S2_MASK = 32'hFFC0_0000;
   localparam logic [31:0] DEF_S3_BASE = 32'h8040_0000;
   localparam logic [31:0] DEF_S3_MASK = 32'hFFC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: per-slave hit vector and lowest-index winner.
module wb_addr_decode
   import wb_periph_mux_pkg::*;
#(
   parameter logic [31:0] S0_BASE = DEF_S0_BASE,
   parameter logic [31:0] S0_MASK = DEF_S0_MASK,
   parameter logic [31:0] S1_BASE = DEF_S1_BASE,
   parameter logic [31:0] S1_MASK = DEF_S1_MASK,
   parameter logic [31:0] S2_BASE = DEF_S2_BASE,
   parameter logic [31:0] S2_MASK = DEF_S2_MASK,
   parameter logic [31:0] S3_BASE = DEF_S3_BASE,
   parameter logic [31:0] S3_MASK = DEF_S3_MASK
) (
   input  logic [31:0]           adr,
   output logic [NUM_SLAVES-1:0] hit,
   output logic [SEL_W-1:0]      idx
);

   assign hit[0] = ((adr & S0_MASK) == S0_BASE);
   assign hit[1] = ((adr & S1_MASK) == S1_BASE);
   assign hit[2] = ((adr & S2_MASK) == S2_BASE);
   assign hit[3] = ((adr & S3_MASK) == S3_BASE);

   // Scan downwards so the lowest matching index is the last one written.
   always_comb begin
      idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if (hit[k]) idx = SEL_W'(k);
      end
   end

endmodule

// File: rtl/wb_periph_mux.sv
// Single-master, four-slave Wishbone interconnect with decode error and BUSY timeout.
module wb_periph_mux
   import wb_periph_mux_pkg::*;
#(
   parameter logic [31:0] S0_BASE = DEF_S0_BASE,
   parameter logic [31:0] S0_MASK = DEF_S0_MASK,
   parameter logic [31:0] S1_BASE = DEF_S1_BASE,
   parameter logic [31:0] S1_MASK = DEF_S1_MASK,
   parameter logic [31:0] S2_BASE = DEF_S2_BASE,
   parameter logic [31:0] S2_MASK = DEF_S2_MASK,
   parameter logic [31:0] S3_BASE = DEF_S3_BASE,
   parameter logic [31:0] S3_MASK = DEF_S3_MASK,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [31:0]                    wbm_adr_i,
   input  logic [31:0]                    wbm_dat_i,
   input  logic                           wbm_we_i,
   input  logic [3:0]                     wbm_sel_i,
   input  logic                           wbm_stb_i,
   input  logic                           wbm_cyc_i,
   output logic [31:0]                    wbm_dat_o,
   output logic                           wbm_ack_o,
   output logic                           wbm_err_o,
   output logic [NUM_SLAVES-1:0][31:0]    wbs_adr_o,
   output logic [NUM_SLAVES-1:0][31:0]    wbs_dat_o,
   output logic [NUM_SLAVES-1:0]          wbs_we_o,
   output logic [NUM_SLAVES-1:0][3:0]     wbs_sel_o,
   output logic [NUM_SLAVES-1:0]          wbs_stb_o,
   output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
   input  logic [NUM_SLAVES-1:0][31:0]    wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]          wbs_ack_i
);

   // The counter holds completed BUSY cycles, so expiry is the TIMEOUT-th BUSY cycle.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [NUM_SLAVES-1:0] hit;
   logic [SEL_W-1:0]      hit_idx;
   logic                  req, busy, live;

   wb_addr_decode #(
      .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
      .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
      .S2_BASE(S2_BASE), .S2_MASK(S2_MASK),
      .S3_BASE(S3_BASE), .S3_MASK(S3_MASK)
   ) u_decode (
      .adr (wbm_adr_i),
      .hit (hit),
      .idx (hit_idx)
   );

   assign req  = wbm_cyc_i & wbm_stb_i;
   assign busy = (state_q == ST_BUSY);
   assign live = busy & wbm_cyc_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (|hit) begin
                  sel_d   = hit_idx;
                  cnt_d   = '0;
                  state_d = ST_BUSY;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            // Abort beats ack, and ack beats timeout expiry.
            if (!wbm_cyc_i)                state_d = ST_IDLE;
            else if (wbs_ack_i[sel_q])     state_d = ST_IDLE;
            else if (cnt_q == CNT_LAST)    state_d = ST_ERR;
            else                           cnt_d   = cnt_q + 8'd1;
         end
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wbs_stb_o = '0;
      wbs_cyc_o = '0;
      if (live) begin
         wbs_stb_o[sel_q] = wbm_stb_i;
         wbs_cyc_o[sel_q] = 1'b1;
      end
   end

   assign wbm_ack_o = live & wbs_ack_i[sel_q];
   assign wbm_err_o = (state_q == ST_ERR);
   assign wbm_dat_o = busy ? wbs_dat_i[sel_q] : 32'd0;

   assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
   assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
   assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
   assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};

endmodule

// File: tb/tb_wb_periph_mux.sv
// Bench for wb_periph_mux: directed scenarios plus randomized traffic against a transaction-level model.
module tb_wb_periph_mux;

   localparam int TO = 8;
   localparam logic [31:0] BASES [4] = '{32'h0200_0000, 32'h1000_0000, 32'h8000_0000, 32'h8040_0000};
   localparam logic [31:0] MASKS [4] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFC0_0000, 32'hFFC0_0000};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [31:0]      m_adr = '0, m_dat = '0;
   logic             m_we = 1'b0, m_stb = 1'b0, m_cyc = 1'b0;
   logic [3:0]       m_sel = '0;
   logic [31:0]      wbm_dat;
   logic             wbm_ack, wbm_err;
   logic [3:0][31:0] s_adr_o, s_dat_o;
   logic [3:0]       s_we_o, s_stb_o, s_cyc_o;
   logic [3:0][3:0]  s_sel_o;
   logic [3:0][31:0] s_dat = '0;
   logic [3:0]       s_ack = '0;

   int total = 0;
   int bad   = 0;

   int m_tgt = -1;
   int m_age = 0;
   bit m_err = 1'b0;

   always #5 clk = ~clk;

   wb_periph_mux #(.TIMEOUT(TO)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .wbm_adr_i (m_adr),
      .wbm_dat_i (m_dat),
      .wbm_we_i  (m_we),
      .wbm_sel_i (m_sel),
      .wbm_stb_i (m_stb),
      .wbm_cyc_i (m_cyc),
      .wbm_dat_o (wbm_dat),
      .wbm_ack_o (wbm_ack),
      .wbm_err_o (wbm_err),
      .wbs_adr_o (s_adr_o),
      .wbs_dat_o (s_dat_o),
      .wbs_we_o  (s_we_o),
      .wbs_sel_o (s_sel_o),
      .wbs_stb_o (s_stb_o),
      .wbs_cyc_o (s_cyc_o),
      .wbs_dat_i (s_dat),
      .wbs_ack_i (s_ack)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Region membership as an address range [base, base | ~mask].
   function automatic int model_decode(input logic [31:0] a);
      for (int k = 0; k < 4; k++) begin
         if (a >= BASES[k] && a <= (BASES[k] | ~MASKS[k])) return k;
      end
      return -1;
   endfunction

   always @(negedge clk) begin : compare
      logic [3:0]  e_stb, e_cyc;
      logic        e_ack, e_err;
      logic [31:0] e_dat;
      logic [1:0]  ti;
      int          d;
      e_stb = '0; e_cyc = '0; e_ack = 1'b0; e_err = 1'b0; e_dat = '0;
      ti = 2'(m_tgt < 0 ? 0 : m_tgt);
      if (rst) begin
         m_tgt = -1; m_age = 0; m_err = 1'b0;
      end else begin
         e_err = m_err;
         if (m_tgt >= 0) begin
            e_dat = s_dat[ti];
            if (m_cyc) begin
               e_cyc[ti] = 1'b1;
               e_stb[ti] = m_stb;
               e_ack     = s_ack[ti];
            end
         end
      end
      chk("m_ack", 32'(wbm_ack), 32'(e_ack));
      chk("m_err", 32'(wbm_err), 32'(e_err));
      chk("m_dat", wbm_dat, e_dat);
      chk("m_stb", 32'(s_stb_o), 32'(e_stb));
      chk("m_cyc", 32'(s_cyc_o), 32'(e_cyc));
      chk("m_ack_err_excl", 32'(wbm_ack & wbm_err), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("bc_adr", s_adr_o[k], m_adr);
         chk("bc_dat", s_dat_o[k], m_dat);
         chk("bc_we_sel", 32'({s_we_o[k], s_sel_o[k]}), 32'({m_we, m_sel}));
      end
      if (!rst) begin
         if (m_err) begin
            m_err = 1'b0;
         end else if (m_tgt < 0) begin
            if (m_cyc && m_stb) begin
               d = model_decode(m_adr);
               if (d < 0) m_err = 1'b1;
               else begin m_tgt = d; m_age = 0; end
            end
         end else if (!m_cyc || s_ack[ti]) begin
            m_tgt = -1;
         end else if (m_age + 1 >= TO) begin
            m_tgt = -1; m_err = 1'b1;
         end else begin
            m_age++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      m_adr = a; m_we = w; m_dat = d; m_sel = s; m_stb = 1'b1; m_cyc = 1'b1;
   endtask

   task automatic idle_bus();
      m_stb = 1'b0; m_cyc = 1'b0; s_ack = '0;
   endtask

   initial begin
      int quiet;
      // Reset state
      tick();
      @(negedge clk);
      chk("rst_ack", 32'(wbm_ack), 32'd0);
      chk("rst_err", 32'(wbm_err), 32'd0);
      chk("rst_dat", wbm_dat, 32'd0);
      chk("rst_stb", 32'(s_stb_o), 32'd0);
      chk("rst_cyc", 32'(s_cyc_o), 32'd0);
      tick(); rst = 1'b0;

      // Read at slave 0 with a registered-ack slave
      tick(); req(32'h0200_BFF8, 1'b0, 32'd0, 4'hF); s_dat[0] = 32'h1234_5678;
      @(negedge clk); chk("rd_s0_req_stb", 32'(s_stb_o), 32'd0);
      tick();
      @(negedge clk); chk("rd_s0_busy_stb", 32'(s_stb_o), 32'b0001);
      chk("rd_s0_busy_ack", 32'(wbm_ack), 32'd0);
      tick(); s_ack = 4'b0001;
      @(negedge clk); chk("rd_s0_ack", 32'(wbm_ack), 32'd1);
      chk("rd_s0_dat", wbm_dat, 32'h1234_5678);
      tick(); idle_bus();
      @(negedge clk); chk("rd_s0_done_stb", 32'(s_stb_o), 32'd0);

      // Write to slave 1
      tick(); req(32'h1000_0004, 1'b1, 32'h41, 4'b0001);
      @(negedge clk);
      tick();
      @(negedge clk); chk("wr_s1_stb", 32'(s_stb_o), 32'b0010);
      chk("wr_s1_dat", s_dat_o[1], 32'h41);
      chk("wr_s1_we", 32'(s_we_o[1]), 32'd1);
      chk("wr_s1_sel", 32'(s_sel_o[1]), 32'b0001);
      tick(); s_ack = 4'b0010;
      @(negedge clk); chk("wr_s1_ack", 32'(wbm_ack), 32'd1);
      tick(); idle_bus();

      // Unmapped address
      tick(); req(32'h4000_0000, 1'b0, 32'd0, 4'hF);
      @(negedge clk); chk("unmap_err0", 32'(wbm_err), 32'd0);
      tick(); idle_bus();
      @(negedge clk); chk("unmap_err1", 32'(wbm_err), 32'd1);
      chk("unmap_stb", 32'(s_stb_o), 32'd0);
      tick();
      @(negedge clk); chk("unmap_err2", 32'(wbm_err), 32'd0);

      // Slave 2 timeout, then ack on the final BUSY cycle
      for (int pass = 0; pass < 2; pass++) begin
         tick(); req(32'h8000_0010, 1'b0, 32'd0, 4'hF); s_ack = '0;
         @(negedge clk);
         for (int i = 1; i <= TO; i++) begin
            tick();
            if (pass == 1 && i == TO) s_ack = 4'b0100;
            @(negedge clk);
            chk("to_busy_stb", 32'(s_stb_o), 32'b0100);
            chk("to_busy_err", 32'(wbm_err), 32'd0);
            if (pass == 1 && i == TO) chk("to_late_ack", 32'(wbm_ack), 32'd1);
         end
         tick(); idle_bus();
         @(negedge clk);
         chk("to_err", 32'(wbm_err), (pass == 0) ? 32'd1 : 32'd0);
         chk("to_stb_drop", 32'(s_stb_o), 32'd0);
         tick();
      end

      // Spurious ack from an unselected slave
      tick(); req(32'h0200_0000, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      tick(); s_ack = 4'b1000;
      @(negedge clk); chk("spur_ack", 32'(wbm_ack), 32'd0);
      tick(); s_ack = 4'b0001;
      @(negedge clk); chk("spur_real_ack", 32'(wbm_ack), 32'd1);
      tick(); idle_bus();

      // Reset mid-BUSY, abort mid-BUSY, then a normal request
      tick(); req(32'h1000_0000, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      tick();
      @(negedge clk); chk("rstb_stb", 32'(s_stb_o), 32'b0010);
      tick(); rst = 1'b1; s_ack = 4'b0010;
      @(negedge clk); chk("rstb_stb_drop", 32'(s_stb_o), 32'd0);
      chk("rstb_ack", 32'(wbm_ack), 32'd0);
      chk("rstb_err", 32'(wbm_err), 32'd0);
      tick(); rst = 1'b0; idle_bus();
      @(negedge clk); chk("rstb_after_err", 32'(wbm_err), 32'd0);
      tick(); req(32'h8040_0000, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      tick();
      @(negedge clk); chk("abort_stb", 32'(s_stb_o), 32'b1000);
      tick(); m_cyc = 1'b0; s_ack = 4'b1000;
      @(negedge clk); chk("abort_stb_drop", 32'(s_stb_o), 32'd0);
      chk("abort_cyc_drop", 32'(s_cyc_o), 32'd0);
      chk("abort_ack", 32'(wbm_ack), 32'd0);
      tick(); idle_bus();
      @(negedge clk); chk("abort_err", 32'(wbm_err), 32'd0);
      tick(); req(32'h0200_0004, 1'b0, 32'd0, 4'hF);
      @(negedge clk);
      tick();
      @(negedge clk); chk("post_stb", 32'(s_stb_o), 32'b0001);
      tick(); s_ack = 4'b0001;
      @(negedge clk); chk("post_ack", 32'(wbm_ack), 32'd1);
      tick(); idle_bus();

      // Randomized traffic; quiet windows suppress acks to provoke timeouts
      quiet = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst = rst ? 1'b0 : ($urandom_range(0, 299) == 0);
         if (n % 60 == 0) quiet = 15;
         if (quiet > 0) quiet--;
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               int k;
               k = $urandom_range(0, 3);
               m_adr = BASES[k] | ($urandom & ~MASKS[k]);
            end
            4: m_adr = $urandom;
            default: ;
         endcase
         m_cyc = ($urandom_range(0, 19) != 0);
         m_stb = m_cyc && ($urandom_range(0, 7) != 0);
         m_we  = 1'($urandom);
         m_sel = 4'($urandom);
         m_dat = $urandom;
         for (int k = 0; k < 4; k++) begin
            s_ack[k] = (quiet == 0) && ($urandom_range(0, 3) == 0);
            s_dat[k] = $urandom;
         end
      end
      tick(); rst = 1'b0; idle_bus();
      tick();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
